// File: rtl/sd_spi_pkg.sv
// Shared encodings for the SPI-mode SD response path: FSM states, response/data modes,
// error codes and protocol constants.
package sd_spi_pkg;

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StWaitR1    = 3'd1;
  localparam logic [2:0] StRespExtra = 3'd2;
  localparam logic [2:0] StBusy      = 3'd3;
  localparam logic [2:0] StWaitToken = 3'd4;
  localparam logic [2:0] StData      = 3'd5;
  localparam logic [2:0] StCrc       = 3'd6;
  localparam logic [2:0] StFinish    = 3'd7;

  typedef enum logic [1:0] {
    RespR1   = 2'd0,
    RespR1b  = 2'd1,
    RespR3R7 = 2'd2,
    RespR2   = 2'd3
  } resp_type_e;

  typedef enum logic [1:0] {
    DataNone   = 2'd0,
    DataSingle = 2'd1,
    DataMulti  = 2'd2,
    DataRsvd   = 2'd3
  } data_mode_e;

  localparam logic [2:0] ErrNone         = 3'd0;
  localparam logic [2:0] ErrR1Timeout    = 3'd1;
  localparam logic [2:0] ErrR1Bits       = 3'd2;
  localparam logic [2:0] ErrTokenTimeout = 3'd3;
  localparam logic [2:0] ErrDataToken    = 3'd4;
  localparam logic [2:0] ErrCrc          = 3'd5;
  localparam logic [2:0] ErrBusyTimeout  = 3'd6;

  localparam logic [7:0]  StartToken = 8'hFE;
  localparam logic [15:0] Crc16Poly  = 16'h1021;

endpackage

// File: rtl/sd_spi_response_receiver_if.sv
// Byte-stream, control and status bundle between the SPI byte buffer / command
// sequencer (master) and the response receiver (slave).
interface sd_spi_response_receiver_if #(
  parameter int unsigned MAX_BLOCK_BYTES = 512
);
  localparam int unsigned BsW = $clog2(MAX_BLOCK_BYTES) + 1;

  logic           io_Start;
  logic [1:0]     io_RespType;
  logic [1:0]     io_DataMode;
  logic [BsW-1:0] io_BlockSize;
  logic           io_Stop;
  logic [7:0]     io_InputBuffer;
  logic           io_BufferChanged;
  logic [7:0]     io_R1;
  logic [31:0]    io_Extra;
  logic [7:0]     io_DataOut;
  logic           io_DataValid;
  logic [31:0]    io_DataBlocksCount;
  logic           io_IsBusy;
  logic           io_IsDataReading;
  logic           io_Done;
  logic           io_Error;
  logic [2:0]     io_ErrCode;
  logic [2:0]     io_State;

  modport master (
    output io_Start, io_RespType, io_DataMode, io_BlockSize, io_Stop, io_InputBuffer,
           io_BufferChanged,
    input  io_R1, io_Extra, io_DataOut, io_DataValid, io_DataBlocksCount, io_IsBusy,
           io_IsDataReading, io_Done, io_Error, io_ErrCode, io_State
  );

  modport slave (
    input  io_Start, io_RespType, io_DataMode, io_BlockSize, io_Stop, io_InputBuffer,
           io_BufferChanged,
    output io_R1, io_Extra, io_DataOut, io_DataValid, io_DataBlocksCount, io_IsBusy,
           io_IsDataReading, io_Done, io_Error, io_ErrCode, io_State
  );
endinterface

// File: rtl/sd_crc16.sv
// Byte-wide CRC16-CCITT update (MSB first), shared with the transmit path.
module sd_crc16
  import sd_spi_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [15:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--) begin
      if (crc_out[15] ^ byte_in[i]) crc_out = {crc_out[14:0], 1'b0} ^ Crc16Poly;
      else                          crc_out = {crc_out[14:0], 1'b0};
    end
  end
endmodule

// File: rtl/sd_spi_response_receiver.sv
// Parses the SD SPI response sequence (R1, trailing bytes, busy, data token, blocks, CRC)
// from the received byte stream and forwards payload bytes downstream.
module sd_spi_response_receiver
  import sd_spi_pkg::*;
#(
  parameter int unsigned MAX_BLOCK_BYTES = 512,
  parameter int unsigned NCR_MAX         = 8,
  parameter int unsigned TOKEN_TIMEOUT   = 4096,
  parameter bit          CRC_CHECK       = 1'b1
) (
  input logic                       clock,
  input logic                       reset,
  sd_spi_response_receiver_if.slave bus
);
  localparam int unsigned BsW   = $clog2(MAX_BLOCK_BYTES) + 1;
  localparam int unsigned TmoW  = $clog2(TOKEN_TIMEOUT + 1);
  localparam int unsigned NcrW  = $clog2(NCR_MAX + 1);
  localparam int unsigned CntW0 = (TmoW > BsW) ? TmoW : BsW;
  localparam int unsigned CntW  = (CntW0 > NcrW) ? CntW0 : NcrW;
  localparam logic [CntW-1:0] NcrLast = CntW'(NCR_MAX - 1);
  localparam logic [CntW-1:0] TmoLast = CntW'(TOKEN_TIMEOUT - 1);

  logic [2:0]      state_q, state_d;
  resp_type_e      resp_q, resp_d;
  data_mode_e      mode_q, mode_d;
  logic [BsW-1:0]  bsize_q, bsize_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [15:0]     crc_q, crc_d, crc_next;
  logic [7:0]      crc_hi_q, crc_hi_d;
  logic [7:0]      r1_q, r1_d, dout_q, dout_d;
  logic [31:0]     extra_q, extra_d, blocks_q, blocks_d;
  logic            dvalid_q, dvalid_d, done_q, done_d, error_q, error_d;
  logic [2:0]      err_q, err_d;
  logic            busy_q, reading_q;

  logic            fail;
  logic [2:0]      fail_code;
  logic [7:0]      rx;
  logic [2:0]      resp_exit;
  logic [CntW-1:0] extra_last, block_last;
  data_mode_e      mode_in;

  assign rx         = bus.io_InputBuffer;
  assign resp_exit  = (mode_q == DataNone) ? StFinish : StWaitToken;
  assign extra_last = (resp_q == RespR3R7) ? CntW'(3) : '0;
  assign block_last = CntW'(bsize_q - BsW'(1));
  assign mode_in    = data_mode_e'(bus.io_DataMode);

  sd_crc16 u_crc16 (
    .crc_in  (crc_q),
    .byte_in (rx),
    .crc_out (crc_next)
  );

  always_comb begin
    state_d   = state_q;
    resp_d    = resp_q;
    mode_d    = mode_q;
    bsize_d   = bsize_q;
    cnt_d     = cnt_q;
    crc_d     = crc_q;
    crc_hi_d  = crc_hi_q;
    r1_d      = r1_q;
    extra_d   = extra_q;
    dout_d    = dout_q;
    dvalid_d  = 1'b0;
    blocks_d  = blocks_q;
    error_d   = 1'b0;
    err_d     = err_q;
    fail      = 1'b0;
    fail_code = ErrNone;

    unique case (state_q)
      StIdle: begin
        if (bus.io_Start) begin
          resp_d   = resp_type_e'(bus.io_RespType);
          mode_d   = (mode_in == DataRsvd) ? DataNone : mode_in;
          bsize_d  = bus.io_BlockSize;
          r1_d     = '0;
          extra_d  = '0;
          blocks_d = '0;
          err_d    = ErrNone;
          cnt_d    = '0;
          state_d  = StWaitR1;
        end
      end
      StWaitR1: begin
        if (bus.io_BufferChanged) begin
          if (!rx[7]) begin
            r1_d  = rx;
            cnt_d = '0;
            if (rx[6:1] != 6'd0) begin
              fail      = 1'b1;
              fail_code = ErrR1Bits;
            end else if (resp_q == RespR3R7 || resp_q == RespR2) begin
              state_d = StRespExtra;
            end else if (resp_q == RespR1b) begin
              state_d = StBusy;
            end else begin
              state_d = resp_exit;
            end
          end else if (cnt_q == NcrLast) begin
            fail      = 1'b1;
            fail_code = ErrR1Timeout;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRespExtra: begin
        if (bus.io_BufferChanged) begin
          extra_d = {extra_q[23:0], rx};
          if (cnt_q == extra_last) begin
            cnt_d   = '0;
            state_d = resp_exit;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StBusy: begin
        if (bus.io_BufferChanged) begin
          if (rx != 8'h00) begin
            state_d = StFinish;
          end else if (cnt_q == TmoLast) begin
            fail      = 1'b1;
            fail_code = ErrBusyTimeout;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StWaitToken: begin
        if (bus.io_BufferChanged) begin
          if (rx == StartToken) begin
            crc_d   = '0;
            cnt_d   = '0;
            state_d = StData;
          end else if (rx[7:5] == 3'b000 && rx != 8'h00) begin
            extra_d[7:0] = rx;
            fail         = 1'b1;
            fail_code    = ErrDataToken;
          end else if (cnt_q == TmoLast) begin
            fail      = 1'b1;
            fail_code = ErrTokenTimeout;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StData: begin
        if (bus.io_BufferChanged) begin
          dout_d   = rx;
          dvalid_d = 1'b1;
          crc_d    = crc_next;
          if (cnt_q == block_last) begin
            cnt_d   = '0;
            state_d = StCrc;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StCrc: begin
        if (bus.io_BufferChanged) begin
          if (cnt_q == '0) begin
            crc_hi_d = rx;
            cnt_d    = CntW'(1);
          end else begin
            cnt_d = '0;
            if (!CRC_CHECK || {crc_hi_q, rx} == crc_q) begin
              if (blocks_q != 32'hFFFF_FFFF) blocks_d = blocks_q + 32'd1;
              // io_Stop is only honoured here, so a mid-block stop finishes this block first
              state_d = (mode_q == DataSingle || bus.io_Stop) ? StFinish : StWaitToken;
            end else begin
              fail      = 1'b1;
              fail_code = ErrCrc;
            end
          end
        end
      end
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (fail) begin
      state_d = StIdle;
      error_d = 1'b1;
      err_d   = fail_code;
    end
    done_d = (state_d == StFinish);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      resp_q    <= RespR1;
      mode_q    <= DataNone;
      bsize_q   <= '0;
      cnt_q     <= '0;
      crc_q     <= '0;
      crc_hi_q  <= '0;
      r1_q      <= '0;
      extra_q   <= '0;
      dout_q    <= '0;
      dvalid_q  <= 1'b0;
      blocks_q  <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_q     <= ErrNone;
      busy_q    <= 1'b0;
      reading_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      resp_q    <= resp_d;
      mode_q    <= mode_d;
      bsize_q   <= bsize_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      crc_hi_q  <= crc_hi_d;
      r1_q      <= r1_d;
      extra_q   <= extra_d;
      dout_q    <= dout_d;
      dvalid_q  <= dvalid_d;
      blocks_q  <= blocks_d;
      done_q    <= done_d;
      error_q   <= error_d;
      err_q     <= err_d;
      busy_q    <= (state_d != StIdle);
      reading_q <= (state_d == StData) || (state_d == StCrc);
    end
  end

  assign bus.io_R1              = r1_q;
  assign bus.io_Extra           = extra_q;
  assign bus.io_DataOut         = dout_q;
  assign bus.io_DataValid       = dvalid_q;
  assign bus.io_DataBlocksCount = blocks_q;
  assign bus.io_IsBusy          = busy_q;
  assign bus.io_IsDataReading   = reading_q;
  assign bus.io_Done            = done_q;
  assign bus.io_Error           = error_q;
  assign bus.io_ErrCode         = err_q;
  assign bus.io_State           = state_q;

endmodule
